// File: rtl/neuron_requant.sv
// Neuron requantizer: accumulates a frame of adder totals, adds bias, round-shifts and
// saturates to an OUT_W activation. Optional feature macro: NEURON_RELU_EN (ReLU clamp at zero).
//
// state  | meaning
// IDLE   | waiting for first beat of a frame
// ACCUM  | summing beats until in_last
// ROUND  | one cycle: bias, round, shift, clamp
// OUTPUT | holding result until out_ready
module neuron_requant #(
  parameter int IN_W  = 17,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8,
  parameter int SH_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_total,
  input  logic                    in_last,
  input  logic signed [15:0]      bias,
  input  logic        [SH_W-1:0]  shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUTPUT} state_t;

  localparam int OMAX = 2**(OUT_W-1) - 1;
  localparam int OMIN = -(2**(OUT_W-1));
  localparam logic signed [ACC_W:0]   SUM_MAX = (ACC_W+1)'(OMAX);
  localparam logic signed [ACC_W:0]   SUM_MIN = (ACC_W+1)'(OMIN);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc;
  logic                    acc_ovf;
  logic signed [15:0]      bias_q;
  logic        [SH_W-1:0]  shift_q;
  logic                    rdy_en;

  logic                    accept;
  logic signed [ACC_W:0]   in_ext;
  logic signed [ACC_W:0]   acc_ext;
  logic signed [ACC_W:0]   acc_sum;
  logic                    sum_ovf;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [ACC_W:0]   bias_ext;
  logic        [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   round_sum;
  logic signed [ACC_W:0]   shifted;
  logic signed [OUT_W-1:0] res_data;
  logic                    res_clamp;

  // in_ready stays low until the first clock after reset release
  assign in_ready = rdy_en && ((state_q == IDLE) || (state_q == ACCUM));
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid && in_ready;

  assign in_ext   = {{(ACC_W+1-IN_W){in_total[IN_W-1]}}, in_total};
  assign acc_ext  = {acc[ACC_W-1], acc};
  assign acc_sum  = acc_ext + in_ext;
  assign sum_ovf  = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
  assign acc_sat  = sum_ovf ? (acc_sum[ACC_W] ? ACC_MIN : ACC_MAX) : acc_sum[ACC_W-1:0];

  assign bias_ext  = {{(ACC_W+1-16){bias_q[15]}}, bias_q};
  assign rnd       = (shift_q == '0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << (shift_q - 1'b1));
  assign round_sum = acc_ext + bias_ext + $signed(rnd);
  assign shifted   = round_sum >>> shift_q;

  always_comb begin
    res_data  = '0;
    res_clamp = 1'b0;
`ifdef NEURON_RELU_EN
    if (shifted < 0) begin
      res_data  = '0;
      res_clamp = 1'b0;
    end else if (shifted > SUM_MAX) begin
      res_data  = OUT_W'(OMAX);
      res_clamp = 1'b1;
    end else begin
      res_data  = shifted[OUT_W-1:0];
    end
`else
    if (shifted > SUM_MAX) begin
      res_data  = OUT_W'(OMAX);
      res_clamp = 1'b1;
    end else if (shifted < SUM_MIN) begin
      res_data  = OUT_W'(OMIN);
      res_clamp = 1'b1;
    end else begin
      res_data  = shifted[OUT_W-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? ROUND : ACCUM;
      ACCUM:   if (accept && in_last) state_d = ROUND;
      ROUND:   state_d = OUTPUT;
      OUTPUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      acc_ovf   <= 1'b0;
      bias_q    <= '0;
      shift_q   <= '0;
      rdy_en    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc     <= in_ext[ACC_W-1:0];
            acc_ovf <= 1'b0;
            if (in_last) begin
              bias_q  <= bias;
              shift_q <= shift;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc_sat;
            if (sum_ovf) acc_ovf <= 1'b1;
            if (in_last) begin
              bias_q  <= bias;
              shift_q <= shift;
            end
          end
        end
        ROUND: begin
          out_data  <= res_data;
          out_sat   <= res_clamp || acc_ovf;
          out_valid <= 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_requant.sv
// Directed bench for neuron_requant: hand-computed frames, stall, saturation and reset cases.
`timescale 1ns/1ps
module tb_neuron_requant;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid;
  logic               in_ready;
  logic signed [16:0] in_total;
  logic               in_last;
  logic signed [15:0] bias;
  logic        [3:0]  shift;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               out_sat;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_requant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_total  (in_total),
    .in_last   (in_last),
    .bias      (bias),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic beat(input int val, input bit last, input int b, input int sh);
    in_valid = 1'b1;
    in_total = 17'(val);
    in_last  = last;
    bias     = 16'(b);
    shift    = 4'(sh);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_out(input string tag, input int exp_d, input int exp_s);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_sat"}, out_sat, exp_s);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid  = 1'b0;
    in_total  = '0;
    in_last   = 1'b0;
    bias      = '0;
    shift     = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("rel_in_ready_high", in_ready, 1);

    // bias/shift on non-last beats must be ignored; idle gap mid-frame
    beat(10, 0, 99, 7);
    @(negedge clk);
    check("t1_gap_busy", busy, 1);
    check("t1_gap_ready", in_ready, 1);
    beat(20, 0, 99, 7);
    beat(-5, 1, 0, 0);
    check("t1_lat_n1_valid", out_valid, 0);
    check("t1_round_ready", in_ready, 0);
    @(negedge clk);
    check("t1_lat_n2_valid", out_valid, 1);
    get_out("t1", 25, 0);

    beat(300, 1, -44, 1);
    get_out("t2", 127, 1);

    beat(-1000, 1, 0, 3);
`ifdef NEURON_RELU_EN
    get_out("t3", 0, 0);
`else
    get_out("t3", -125, 0);
`endif

    beat(3, 1, 0, 1);
    get_out("t4p", 2, 0);
    beat(-3, 1, 0, 1);
`ifdef NEURON_RELU_EN
    get_out("t4n", 0, 0);
`else
    get_out("t4n", -1, 0);
`endif

    beat(-2000, 1, 0, 0);
`ifdef NEURON_RELU_EN
    get_out("negclamp", 0, 0);
`else
    get_out("negclamp", -128, 1);
`endif

    // stall in OUTPUT with a pending beat that must not be taken
    beat(7, 1, 0, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_total = 17'sd50;
    in_last  = 1'b1;
    bias     = '0;
    shift    = '0;
    for (int i = 0; i < 5; i++) begin
      check("t5_stall_valid", out_valid, 1);
      check("t5_stall_data", out_data, 7);
      check("t5_stall_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t5_post_hs_ready", in_ready, 1);
    check("t5_post_hs_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t5_next_accepted", busy, 1);
    get_out("t5_next", 50, 0);

    for (int i = 0; i < 199; i++) beat(65535, 0, 0, 0);
    beat(65535, 1, 0, 15);
    get_out("t6_accsat", 127, 1);

    // accumulator clamps high then returns in range: only the sticky flag flags it
    for (int i = 0; i < 130; i++) beat(65535, 0, 0, 0);
    for (int i = 0; i < 128; i++) beat(-65536, 0, 0, 0);
    beat(0, 1, 0, 0);
`ifdef NEURON_RELU_EN
    get_out("ovf_sticky", 0, 1);
`else
    get_out("ovf_sticky", -1, 1);
`endif

    for (int i = 0; i < 5; i++) beat(1000, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(4, 1, 0, 0);
    get_out("after_rst", 4, 0);

    beat(9, 1, 0, 0);
    @(negedge clk);
    check("rst_out_pre", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid_drop", out_valid, 0);
    check("rst_out_data_clr", out_data, 0);
    check("rst_out_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
